rsff_bank_init_seq: RTL
=======================

Name: rsff_bank_init_seq

Overview:
Sequencer that loads an initial pattern into a bank of WIDTH set/reset flip-flops (the TECH_RSFF cell class) by driving only their set and reset pins. A start/busy/done handshake runs a fixed sequence: clear the whole bank, wait for recovery, set the pattern bits, wait again, then read back and compare. Used by the init/config logic ahead of normal clocked operation. It guarantees that set and reset are never both asserted on the same bit.

Parameters:
WIDTH, 8, number of flops in the bank
PULSE, 2, cycles each set or reset pulse is held; legal range is 1 and above
GAP, 1, recovery cycles with all pins low after each pulse; legal range is 0 and above, and 0 skips the gap states

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
start  input  1  request; sampled only in IDLE
pattern  input  WIDTH  target bank value; captured into pat_r on accepted start
bank_q  input  WIDTH  readback of the bank's q outputs
rst_o  output  WIDTH  per-bit reset drive to the bank, active high
set_o  output  WIDTH  per-bit set drive to the bank, active high
busy  output  1  high from the accepted start through CHECK
done  output  1  one-cycle completion pulse
err  output  1  readback mismatch flag; valid from done onward
err_mask  output  WIDTH  per-bit mismatch, equal to bank_q XOR pat_r

Behaviour:
- All outputs are registered.
- While reset is low at a clock edge:
  - state goes to IDLE;
  - pat_r, counter, rst_o, set_o, busy, done, err and err_mask are all 0.
  - This applies mid-sequence as well: outputs are 0 after that edge, no done is issued, and the sequence does not resume.
- States: IDLE, CLEAR, CLR_GAP, SET, SET_GAP, CHECK, DONE.
- IDLE:
  - All drives are 0 and busy is 0.
  - When start=1: capture pat_r<=pattern, clear err and err_mask, load counter=PULSE-1, go to CLEAR.
- CLEAR:
  - rst_o is all ones, set_o is 0.
  - Decrement the counter. At 0, go to CLR_GAP with counter=GAP-1, or go directly to SET with counter=PULSE-1 if GAP=0.
- CLR_GAP: all drives 0. At counter 0, go to SET with counter=PULSE-1.
- SET:
  - set_o=pat_r, rst_o=0.
  - At counter 0, go to SET_GAP, or go directly to CHECK if GAP=0.
- SET_GAP: all drives 0. At counter 0, go to CHECK.
- CHECK:
  - Lasts one cycle with all drives 0.
  - On exit, register err_mask<=bank_q^pat_r and err<=|(bank_q^pat_r), then go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0. Go to IDLE.
  - err and err_mask hold until the next accepted start or reset.
- busy is 1 in CLEAR, CLR_GAP, SET, SET_GAP and CHECK.
- start is ignored while busy and in DONE. A new start is accepted in the first IDLE cycle after DONE.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+2*PULSE+2*GAP+1. With defaults that is edge k+7.
- Invariant, every cycle: (rst_o & set_o)==0. Verification checks this with an assertion.
- Pattern changes after the start edge have no effect.
- Counter width is clog2(max(PULSE,GAP,1))+1. There is no wrap; the counter is reloaded on every state entry.

Test Plan:
- Defaults, pattern=8'hA5, behavioural RSFF bank model -> rst_o=8'hFF for 2 cycles, then 1 zero cycle, then set_o=8'hA5 for 2 cycles, then 1 zero cycle, then CHECK. done pulses 7 edges after start, err=0, err_mask=8'h00, and the bank holds 8'hA5.
- Bank bit 3 stuck at 0, pattern=8'hFF -> done with err=1 and err_mask=8'h08. err stays high after done until the next start, where it clears.
- start held high for 20 cycles -> exactly one sequence while busy, done once, then a second sequence starts in the first IDLE cycle after DONE. pattern changes mid-sequence do not alter set_o.
- reset driven low for 1 cycle during the second SET cycle -> rst_o, set_o, busy and done are all 0 after that edge. No done follows. The next start runs the full sequence.
- GAP=0, PULSE=1, pattern=8'h3C -> rst_o=8'hFF for 1 cycle, then immediately set_o=8'h3C for 1 cycle, then CHECK. done 3 edges after start.
- Across all runs, including random pattern and start stimulus: (rst_o & set_o) is never nonzero, and busy and done are never both high.

Source files
------------

// File: rtl/rsff_bank_init_seq.sv
// rsff_bank_init_seq: loads an initial value into a bank of set/reset flops
// by clearing the whole bank, waiting, pulsing set on the pattern bits,
// waiting again, then comparing the bank readback against the pattern.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-low reset
//   start    - sequence request, sampled only in IDLE
//   pattern  - target bank value, captured on the accepted start
//   bank_q   - readback of the bank q outputs
//   rst_o    - per-bit reset drive to the bank (active high)
//   set_o    - per-bit set drive to the bank (active high)
//   busy     - high from the accepted start through CHECK
//   done     - one-cycle completion pulse
//   err      - readback mismatch flag, valid from done onward
//   err_mask - per-bit mismatch (bank_q ^ captured pattern)
module rsff_bank_init_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PULSE = 2,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] bank_q,
    output logic [WIDTH-1:0] rst_o,
    output logic [WIDTH-1:0] set_o,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);

    localparam int unsigned MAX_PG  = (PULSE > GAP) ? PULSE : GAP;
    localparam int unsigned MAX_CNT = (MAX_PG > 1) ? MAX_PG : 1;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int unsigned GAP_M1  = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_M1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CLR_GAP,
        S_SET,
        S_SET_GAP,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   pat_r;

    // Sequencer: drives are registered alongside the state that owns them,
    // so each drive value appears exactly in the cycles of its state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pat_r    <= '0;
            rst_o    <= '0;
            set_o    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_mask <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rst_o <= '0;
                    set_o <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        pat_r    <= pattern;
                        err      <= 1'b0;
                        err_mask <= '0;
                        cnt      <= PULSE_LD;
                        rst_o    <= '1;
                        busy     <= 1'b1;
                        state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (cnt == '0) begin
                        rst_o <= '0;
                        if (GAP == 0) begin
                            set_o <= pat_r;
                            cnt   <= PULSE_LD;
                            state <= S_SET;
                        end else begin
                            cnt   <= GAP_LD;
                            state <= S_CLR_GAP;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_CLR_GAP: begin
                    if (cnt == '0) begin
                        set_o <= pat_r;
                        cnt   <= PULSE_LD;
                        state <= S_SET;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SET: begin
                    if (cnt == '0) begin
                        set_o <= '0;
                        if (GAP == 0) begin
                            state <= S_CHECK;
                        end else begin
                            cnt   <= GAP_LD;
                            state <= S_SET_GAP;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SET_GAP: begin
                    if (cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    // Bank has been quiet for the gap, so readback is settled.
                    err_mask <= bank_q ^ pat_r;
                    err      <= |(bank_q ^ pat_r);
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    rst_o <= '0;
                    set_o <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
